// File: rtl/spi_gen_pkg.sv
// Shared state encodings and command constants for the generic SPI slave front end.
package spi_gen_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    CHK_CMD   = 3'b001,
    WRITE     = 3'b010,
    READ_ADD  = 3'b011,
    READ_DATA = 3'b100
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-load shifter that owns MISO: one bit per cycle, then returns the line to 0.
module spi_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  miso,
  output logic                  active,
  output logic                  done
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;

  // done marks the edge that retires the final bit; a clear on that edge wins.
  assign done = active && (cnt == '0) && !clear;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg  <= '0;
      cnt    <= '0;
      miso   <= 1'b0;
      active <= 1'b0;
    end else if (clear) begin
      shreg  <= '0;
      cnt    <= '0;
      miso   <= 1'b0;
      active <= 1'b0;
    end else if (load) begin
      miso   <= LSB_FIRST ? data[0] : data[DATA_WIDTH-1];
      shreg  <= LSB_FIRST ? (data >> 1) : (data << 1);
      cnt    <= CW'(DATA_WIDTH - 1);
      active <= 1'b1;
    end else if (active) begin
      if (cnt == '0) begin
        miso   <= 1'b0;
        active <= 1'b0;
      end else begin
        miso  <= LSB_FIRST ? shreg[0] : shreg[DATA_WIDTH-1];
        shreg <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
        cnt   <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave front end: routes frames, assembles {cmd, payload} words and serialises read data.
//   state     | meaning
//   IDLE      | waiting for ss_n low
//   CHK_CMD   | sampling the route bit
//   WRITE     | receiving a write frame
//   READ_ADD  | receiving a read-address frame
//   READ_DATA | receiving a read-data frame, then transmitting tx_data
module spi_slave_gen #(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ss_n,
  input  logic                  MOSI,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  MISO,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);
  import spi_gen_pkg::*;

  localparam int FRAME_BITS = DATA_WIDTH + 2;
  localparam int CW         = $clog2(FRAME_BITS);

  state_t                state, state_nxt;
  logic [CW-1:0]         rx_cnt;
  logic [1:0]            cmd_sh;
  logic [DATA_WIDTH-1:0] pay_sh, pay_nxt;
  logic                  rx_done, rd_addr_seen, tx_started;
  logic                  in_rx_state, receiving, abort, incomplete;
  logic                  tx_load, tx_active, tx_done;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_rx_state = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    abort       = (state != IDLE) && ss_n;
    receiving   = in_rx_state && !rx_done && !ss_n;
    pay_nxt     = LSB_FIRST ? {MOSI, pay_sh[DATA_WIDTH-1:1]} : {pay_sh[DATA_WIDTH-2:0], MOSI};
    tx_load     = (state == READ_DATA) && rx_done && !tx_started && tx_valid && !ss_n;
    // Waiting for tx_valid counts as an unfinished read-data frame.
    incomplete  = (state == CHK_CMD) ||
                  (in_rx_state && (!rx_done ||
                   ((state == READ_DATA) && (!tx_started || tx_active))));
    case (state)
      IDLE:     if (!ss_n) state_nxt = CHK_CMD;
      CHK_CMD: begin
        if (ss_n)              state_nxt = IDLE;
        else if (!MOSI)        state_nxt = WRITE;
        else if (rd_addr_seen) state_nxt = READ_DATA;
        else                   state_nxt = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: if (ss_n) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_cnt       <= '0;
      cmd_sh       <= '0;
      pay_sh       <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      rx_done      <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_started   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (abort) begin
        rx_cnt     <= '0;
        cmd_sh     <= '0;
        pay_sh     <= '0;
        rx_done    <= 1'b0;
        tx_started <= 1'b0;
        frame_err  <= incomplete;
      end else begin
        if (state == CHK_CMD) rx_cnt <= CW'(FRAME_BITS - 1);
        if (receiving) begin
          if (rx_cnt >= CW'(DATA_WIDTH)) cmd_sh <= {cmd_sh[0], MOSI};
          else                           pay_sh <= pay_nxt;
          if (rx_cnt == '0) begin
            rx_data  <= {cmd_sh, pay_nxt};
            rx_valid <= 1'b1;
            rx_done  <= 1'b1;
            if (state == READ_ADD) rd_addr_seen <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
        if (tx_load) tx_started <= 1'b1;
      end
      if (tx_done) rd_addr_seen <= 1'b0;
    end
  end

  spi_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (abort),
    .load  (tx_load),
    .data  (tx_data),
    .miso  (MISO),
    .active(tx_active),
    .done  (tx_done)
  );

endmodule

// File: tb/tb_spi_slave_gen.sv
// Bench for spi_slave_gen: an 8-bit MSB-first and a 16-bit LSB-first instance against a frame-level model.
module tb_spi_slave_gen;
  import spi_gen_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ss_a, mosi_a, txv_a, miso_a, rxv_a, err_a, busy_a;
  logic [7:0]  txd_a;
  logic [9:0]  rxd_a;
  logic        ss_b, mosi_b, txv_b, miso_b, rxv_b, err_b, busy_b;
  logic [15:0] txd_b;
  logic [17:0] rxd_b;

  spi_slave_gen #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .ss_n(ss_a), .MOSI(mosi_a), .tx_valid(txv_a), .tx_data(txd_a),
    .MISO(miso_a), .rx_data(rxd_a), .rx_valid(rxv_a), .frame_err(err_a), .busy(busy_a));

  spi_slave_gen #(.DATA_WIDTH(16), .LSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .ss_n(ss_b), .MOSI(mosi_b), .tx_valid(txv_b), .tx_data(txd_b),
    .MISO(miso_b), .rx_data(rxd_b), .rx_valid(rxv_b), .frame_err(err_b), .busy(busy_b));

  int vectors = 0;
  int miscompares = 0;
  bit seen [2];   // model of the read-address-seen flag per instance

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic ss, input logic mosi);
    if (sel) begin ss_b = ss; mosi_b = mosi; end
    else     begin ss_a = ss; mosi_a = mosi; end
  endtask

  task automatic set_tx(input bit sel, input logic v, input logic [15:0] d);
    if (sel) begin txv_b = v; txd_b = d; end
    else     begin txv_a = v; txd_a = d[7:0]; end
  endtask

  function automatic logic o_rxv(input bit sel);  return sel ? rxv_b  : rxv_a;  endfunction
  function automatic logic o_err(input bit sel);  return sel ? err_b  : err_a;  endfunction
  function automatic logic o_busy(input bit sel); return sel ? busy_b : busy_a; endfunction
  function automatic logic o_miso(input bit sel); return sel ? miso_b : miso_a; endfunction
  function automatic logic [31:0] o_rxd(input bit sel);
    return sel ? 32'(rxd_b) : 32'(rxd_a);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 1); drive(1, 0, 1);
    set_tx(0, 0, 16'h0); set_tx(1, 0, 16'h0);
    tick(); tick();
    for (int s = 0; s < 2; s++) begin
      chk("rst_miso",  o_miso(s[0]), 0);
      chk("rst_rxv",   o_rxv(s[0]),  0);
      chk("rst_err",   o_err(s[0]),  0);
      chk("rst_rxd",   o_rxd(s[0]),  0);
      chk("rst_busy",  o_busy(s[0]), 0);
    end
    rst_n = 1'b1;
    drive(0, 1, 0); drive(1, 1, 0);
    seen[0] = 0; seen[1] = 0;
    tick();
  endtask

  // nsend < 0 aborts before the route bit; nsend < w+2 aborts mid-receive.
  // tx_cut > 0 aborts a real transmission after that many MISO bits.
  task automatic frame(input bit sel, input bit route, input logic [1:0] cmd, input logic [15:0] pay,
                       input int nsend, input bit do_tx, input logic [15:0] txd, input int tx_cut);
    int w, nv, lim;
    bit lsb, rd_data, exp_err, b;
    logic [31:0] word;
    w   = sel ? 16 : 8;
    lsb = sel;
    drive(sel, 0, 1'($urandom));
    tick();
    if (nsend < 0) begin
      drive(sel, 1, 0); tick();
      chk("err_chk_abort", o_err(sel), 1);
      chk("busy_chk_abort", o_busy(sel), 0);
      tick();
      chk("err_one_cycle", o_err(sel), 0);
      return;
    end
    rd_data = route && seen[sel];
    drive(sel, 0, route); tick();
    chk("busy_in_frame", o_busy(sel), 1);
    nv = 0;
    for (int i = 0; i < nsend; i++) begin
      if (i == 0)      b = cmd[1];
      else if (i == 1) b = cmd[0];
      else             b = lsb ? pay[i-2] : pay[w-1-(i-2)];
      drive(sel, 0, b); tick();
      nv += int'(o_rxv(sel));
    end
    if (nsend < w + 2) begin
      drive(sel, 1, 1'($urandom)); tick();
      nv += int'(o_rxv(sel));
      chk("rxv_on_abort", 32'(nv), 0);
      chk("err_rx_abort", o_err(sel), 1);
      chk("busy_rx_abort", o_busy(sel), 0);
      tick();
      chk("err_one_cycle", o_err(sel), 0);
      return;
    end
    drive(sel, 0, 1'($urandom)); tick();
    nv += int'(o_rxv(sel));
    chk("rxv_count", 32'(nv), 1);
    word = (32'(cmd) << w) | (32'(pay) & ((32'd1 << w) - 32'd1));
    chk("rx_data", o_rxd(sel), word);
    if (route && !rd_data) seen[sel] = 1;
    exp_err = 0;
    if (do_tx) begin
      set_tx(sel, 1, txd); tick();
      set_tx(sel, 0, 16'($urandom));
      lim = (rd_data && tx_cut > 0 && tx_cut < w) ? tx_cut : w;
      for (int k = 0; k < lim; k++) begin
        logic eb;
        eb = rd_data ? (lsb ? txd[k] : txd[w-1-k]) : 1'b0;
        if (k > 0) tick();
        chk("miso_bit", o_miso(sel), eb);
      end
      if (lim == w) begin
        tick();
        chk("miso_idle", o_miso(sel), 0);
        if (rd_data) seen[sel] = 0;
      end else begin
        exp_err = 1;
      end
    end else begin
      exp_err = rd_data;
    end
    drive(sel, 1, 0); tick();
    chk("err_on_release", o_err(sel), exp_err);
    chk("miso_release", o_miso(sel), 0);
    chk("busy_release", o_busy(sel), 0);
    chk("rx_hold", o_rxd(sel), word);
    if (exp_err) begin
      tick();
      chk("err_one_cycle", o_err(sel), 0);
    end
  endtask

  initial begin
    bit sel, route;
    int w, r, nsend, cut;
    drive(0, 1, 0); drive(1, 1, 0);
    set_tx(0, 0, 16'h0); set_tx(1, 0, 16'h0);
    rst_n = 1'b1;
    do_reset();

    frame(0, 0, CMD_WR_ADDR, 16'h00A5, 10, 0, 16'h0, 0);
    frame(0, 0, CMD_WR_DATA, 16'h003C, 10, 0, 16'h0, 0);
    frame(0, 1, CMD_RD_ADDR, 16'h007F, 10, 1, 16'h00E9, 0);
    frame(0, 1, CMD_RD_DATA, 16'h0000, 10, 1, 16'h00E9, 0);
    frame(0, 1, CMD_RD_DATA, 16'h0055, 10, 1, 16'h00FF, 0);

    do_reset();
    frame(0, 1, CMD_RD_DATA, 16'h0055, 10, 1, 16'h00FF, 0);
    frame(0, 0, CMD_WR_ADDR, 16'h00FF, 6, 0, 16'h0, 0);
    frame(0, 0, CMD_WR_ADDR, 16'h0012, 10, 0, 16'h0, 0);
    frame(0, 0, CMD_WR_ADDR, 16'h0000, -1, 0, 16'h0, 0);
    frame(0, 1, CMD_RD_DATA, 16'h00C3, 10, 0, 16'h0, 0);
    frame(0, 1, CMD_RD_DATA, 16'h0011, 10, 1, 16'h00C3, 3);
    frame(0, 1, CMD_RD_DATA, 16'h0022, 10, 1, 16'h005A, 0);

    frame(1, 0, CMD_WR_DATA, 16'h8001, 18, 0, 16'h0, 0);
    frame(1, 1, CMD_RD_ADDR, 16'h1234, 18, 0, 16'h0, 0);
    frame(1, 1, CMD_RD_DATA, 16'hBEEF, 18, 1, 16'h0003, 0);

    repeat (60) begin
      sel   = 1'($urandom);
      route = 1'($urandom);
      w     = sel ? 16 : 8;
      r     = $urandom_range(0, 7);
      if (r == 0)      nsend = -1;
      else if (r == 1) nsend = $urandom_range(0, w + 1);
      else             nsend = w + 2;
      cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, w - 1) : 0;
      frame(sel, route, 2'($urandom), 16'($urandom), nsend, 1'($urandom), 16'($urandom), cut);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
